// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the byte width used by
// uart_rx / uart_tx / uart_tx_arbiter.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  localparam logic [1:0] ARB_IDLE      = 2'b00;
  localparam logic [1:0] ARB_START     = 2'b01;
  localparam logic [1:0] ARB_WAIT_BUSY = 2'b10;
  localparam logic [1:0] ARB_WAIT_DONE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = ARB_IDLE,
    S_START     = ARB_START,
    S_WAIT_BUSY = ARB_WAIT_BUSY,
    S_WAIT_DONE = ARB_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_select.sv
// Combinational round-robin selector.
//   req_in  : request vector
//   ptr_in  : index of the last owner; search starts at ptr_in+1 and wraps
//   gnt_out : one-hot winner (0 when no request)
//   vld_out : any request present
module uart_rr_select #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [PW-1:0]      ptr_in,
  output logic [NUM_REQ-1:0] gnt_out,
  output logic               vld_out
);

  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] dbl_oh;

  // Low half holds only requests above the pointer, high half holds all of
  // them; the lowest set bit of the concatenation is the wrapped winner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) mask[i] = (i > int'(ptr_in));
    dbl    = {req_in, req_in & mask};
    dbl_oh = dbl & (-dbl);
  end

  assign gnt_out = dbl_oh[2*NUM_REQ-1:NUM_REQ] | dbl_oh[NUM_REQ-1:0];
  assign vld_out = |req_in;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream
// requesters. An owner keeps the transmitter until its byte marked last has
// been sent; a transmitter that never raises busy sets a sticky error.
//   clk_in, nrst_in   : clock, asynchronous active-low reset
//   req_in/data_in/last_in : per-requester byte valid, byte, end-of-burst
//   ack_out           : one-cycle accept pulse, coincident with tx_start_out
//   grant_out         : one-hot owner, 0 when idle
//   tx_start_out/tx_data_out/tx_busy_in : transmitter handshake
//   err_timeout_out   : sticky start timeout
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int START_TIMEOUT = 16
) (
  input  logic                         clk_in,
  input  logic                         nrst_in,
  input  logic [NUM_REQ-1:0]           req_in,
  input  logic [NUM_REQ*DATA_BITS-1:0] data_in,
  input  logic [NUM_REQ-1:0]           last_in,
  output logic [NUM_REQ-1:0]           ack_out,
  output logic [NUM_REQ-1:0]           grant_out,
  output logic                         tx_start_out,
  output logic [DATA_BITS-1:0]         tx_data_out,
  input  logic                         tx_busy_in,
  output logic                         err_timeout_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  generate
    if (NUM_REQ < 2) begin : g_param_chk
      $error("uart_tx_arbiter: NUM_REQ must be at least 2");
    end
  endgenerate

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic [NUM_REQ-1:0]   sel_gnt;
  logic                 sel_vld;
  logic [PW-1:0]        sel_idx;

  uart_rr_select #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req_in  (req_in),
    .ptr_in  (ptr_q),
    .gnt_out (sel_gnt),
    .vld_out (sel_vld)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_gnt[i]) sel_idx = PW'(i);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    err_d   = err_q;
    start_d = 1'b0;
    ack_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_vld && !tx_busy_in) begin
          grant_d = sel_gnt;
          owner_d = sel_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        if (req_in[owner_q]) begin
          start_d = 1'b1;
          ack_d   = grant_q;
          data_d  = data_in[int'(owner_q)*DATA_BITS +: DATA_BITS];
          last_d  = last_in[owner_q];
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          // Withdrawn request forfeits its turn.
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end
      end
      S_WAIT_BUSY: begin
        // cnt_q counts edges since the start pulse minus one, so the error
        // lands exactly START_TIMEOUT cycles after tx_start_out.
        if (tx_busy_in) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_in) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = owner_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      err_q   <= err_d;
      start_q <= start_d;
      ack_q   <= ack_d;
    end
  end

  assign grant_out       = grant_q;
  assign ack_out         = ack_q;
  assign tx_start_out    = start_q;
  assign tx_data_out     = data_q;
  assign err_timeout_out = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk_in = 1'b0;
  logic          nrst_in = 1'b0;
  logic [N-1:0]  req_in = '0;
  logic [N*DW-1:0] data_in = '0;
  logic [N-1:0]  last_in = '0;
  logic [N-1:0]  ack_out, grant_out;
  logic          tx_start_out;
  logic [DW-1:0] tx_data_out;
  logic          tx_busy_in = 1'b0;
  logic          err_timeout_out;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .START_TIMEOUT(TO)) dut (
    .clk_in          (clk_in),
    .nrst_in         (nrst_in),
    .req_in          (req_in),
    .data_in         (data_in),
    .last_in         (last_in),
    .ack_out         (ack_out),
    .grant_out       (grant_out),
    .tx_start_out    (tx_start_out),
    .tx_data_out     (tx_data_out),
    .tx_busy_in      (tx_busy_in),
    .err_timeout_out (err_timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Transmitter model: start -> optional latency -> busy for a number of cycles.
  logic tx_mute = 1'b0, rand_tx = 1'b0, pend = 1'b0;
  int   len_fix = 12, lat_cnt = 0, busy_cnt = 0;
  always @(posedge clk_in) begin
    if (!nrst_in) begin
      pend       <= 1'b0;
      tx_busy_in <= 1'b0;
    end else if (tx_start_out && !tx_mute) begin
      pend    <= 1'b1;
      lat_cnt <= rand_tx ? int'($urandom_range(0, 4)) : 0;
    end else if (pend) begin
      if (lat_cnt == 0) begin
        pend       <= 1'b0;
        tx_busy_in <= 1'b1;
        busy_cnt   <= rand_tx ? int'($urandom_range(3, 20)) : len_fix;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (tx_busy_in) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt <= 1) tx_busy_in <= 1'b0;
    end
  end

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          last;
    int            t;
  } exp_t;

  exp_t          expq[$];
  logic [DW:0]   rq[N][$];   // bytes the requesters still have to offer
  logic [DW:0]   mq[N][$];   // same bytes, consumed by the reference model
  int            mptr = N - 1;
  logic          man_en = 1'b0;

  int   n_pass = 0, n_tot = 0;
  int   fall_cyc = -100, last_start_cyc = 0;
  logic busy_prev = 1'b0, have_prev = 1'b0, prev_last = 1'b1;

  task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive();
    logic [DW:0] h;
    for (int i = 0; i < N; i++) begin
      if (ack_out[i] && rq[i].size() > 0) h = rq[i].pop_front();
      if (!man_en) begin
        if (rq[i].size() > 0) begin
          h = rq[i][0];
          req_in[i]  = 1'b1;
          last_in[i] = h[DW];
          data_in[i*DW +: DW] = h[DW-1:0];
        end else begin
          req_in[i]  = 1'b0;
          last_in[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    drive();
  endtask

  task automatic push_byte(input int i, input logic [DW-1:0] d, input logic l);
    rq[i].push_back({l, d});
    mq[i].push_back({l, d});
  endtask

  // Reference: repeatedly serve the next non-empty requester after the
  // pointer, one whole burst at a time; the pointer then moves to it.
  task automatic plan(input int t_first);
    int t, j;
    logic found;
    logic [DW:0] h;
    exp_t e;
    t = t_first;
    while (1) begin
      found = 1'b0;
      j = 0;
      for (int k = 1; k <= N; k++)
        if (!found && mq[(mptr + k) % N].size() > 0) begin
          found = 1'b1;
          j = (mptr + k) % N;
        end
      if (!found) break;
      do begin
        h = mq[j].pop_front();
        e.src = j; e.data = h[DW-1:0]; e.last = h[DW]; e.t = t;
        t = -1;
        expq.push_back(e);
      end while (!h[DW] && mq[j].size() > 0);
      mptr = j;
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while (k < max && !(expq.size() == 0 && grant_out == '0 && !tx_busy_in && !pend)) begin
      tick();
      k++;
    end
    check(name, k < max, k, max);
  endtask

  task automatic mon_step();
    exp_t e;
    logic [N-1:0] oh;
    if (!nrst_in) begin
      have_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !tx_busy_in) fall_cyc = cyc;
      busy_prev = tx_busy_in;
      if (have_prev && prev_last && cyc == fall_cyc + 1)
        check("release_after_busy", grant_out == '0, grant_out, 0);
      if (tx_start_out) begin
        check("start_expected", expq.size() > 0, tx_data_out, 0);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          oh = '0;
          oh[e.src] = 1'b1;
          check("start_grant", grant_out == oh, grant_out, oh);
          check("start_ack", ack_out == oh, ack_out, oh);
          check("start_data", tx_data_out == e.data, tx_data_out, e.data);
          if (e.t >= 0) check("start_latency", cyc == e.t, cyc, e.t);
          if (have_prev && !prev_last) check("byte_gap", cyc - fall_cyc == 2, cyc - fall_cyc, 2);
          have_prev = 1'b1;
          prev_last = e.last;
          last_start_cyc = cyc;
        end
      end else if (ack_out != '0) begin
        check("ack_without_start", ack_out == '0, ack_out, 0);
      end
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_in);
        mon_step();
      end
      begin : stim
        int k, n;
        logic any;
        // reset state
        repeat (3) tick();
        check("rst_grant", grant_out == '0, grant_out, 0);
        check("rst_ack", ack_out == '0, ack_out, 0);
        check("rst_start", tx_start_out == 1'b0, tx_start_out, 0);
        check("rst_data", tx_data_out == '0, tx_data_out, 0);
        check("rst_err", err_timeout_out == 1'b0, err_timeout_out, 0);
        nrst_in = 1'b1;

        // all four requesting, single-byte bursts: order 0,1,2,3,0
        push_byte(0, 8'h10, 1'b1); push_byte(0, 8'h14, 1'b1);
        push_byte(1, 8'h11, 1'b1); push_byte(2, 8'h12, 1'b1); push_byte(3, 8'h13, 1'b1);
        tick(); plan(cyc + 2);
        wait_drain("rr_drain", 2000);

        // single byte with an 80-cycle transmitter
        len_fix = 80;
        push_byte(1, 8'hA5, 1'b1);
        tick(); plan(cyc + 2);
        wait_drain("single_drain", 500);

        // burst lock: requester 2 keeps the line while 0 waits
        len_fix = 12;
        push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h33, 1'b1);
        push_byte(0, 8'h44, 1'b1);
        tick(); plan(-1);
        wait_drain("burst_drain", 1000);

        // randomized bursts and transmitter timing
        rand_tx = 1'b1;
        for (int r = 0; r < 8; r++) begin
          any = 1'b0;
          for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1) begin
              n = int'($urandom_range(1, 3));
              for (int b = 0; b < n; b++) push_byte(i, 8'($urandom), b == n - 1);
              any = 1'b1;
            end
          if (!any) push_byte(int'($urandom_range(0, N - 1)), 8'($urandom), 1'b1);
          tick(); plan(-1);
          wait_drain("rand_drain", 3000);
        end
        rand_tx = 1'b0;

        // transmitter never answers
        tx_mute = 1'b1;
        push_byte(2, 8'h5C, 1'b1);
        tick(); plan(-1);
        k = 0;
        while (expq.size() > 0 && k < 50) begin tick(); k++; end
        check("timeout_start_seen", expq.size() == 0, k, 50);
        k = 0;
        while (!err_timeout_out && k < 50) begin tick(); k++; end
        check("timeout_cycles", err_timeout_out && (cyc - last_start_cyc == TO), cyc - last_start_cyc, TO);
        check("timeout_release", grant_out == '0, grant_out, 0);
        tx_mute = 1'b0;
        push_byte(0, 8'h3E, 1'b1);
        tick(); plan(-1);
        wait_drain("post_timeout_drain", 500);
        check("err_sticky", err_timeout_out == 1'b1, err_timeout_out, 1);

        // request withdrawn in the START cycle (pointer is 2 beforehand)
        push_byte(2, 8'h77, 1'b1);
        tick(); plan(-1);
        wait_drain("pre_withdraw_drain", 500);
        man_en = 1'b1;
        req_in = 4'b1000; last_in = 4'b1000; data_in[3*DW +: DW] = 8'hEE;
        tick();
        check("wd_grant", grant_out == 4'b1000, grant_out, 4'b1000);
        req_in = '0;
        tick();
        check("wd_no_start", tx_start_out == 1'b0, tx_start_out, 0);
        check("wd_no_ack", ack_out == '0, ack_out, 0);
        check("wd_released", grant_out == '0, grant_out, 0);
        mptr = 3;
        man_en = 1'b0;
        push_byte(3, 8'h31, 1'b1); push_byte(0, 8'h30, 1'b1);
        tick(); plan(-1);
        wait_drain("post_withdraw_drain", 500);

        // asynchronous reset in the middle of a burst
        len_fix = 80;
        push_byte(1, 8'h61, 1'b0); push_byte(1, 8'h62, 1'b0); push_byte(1, 8'h63, 1'b1);
        tick(); plan(-1);
        k = 0;
        while (expq.size() > 2 && k < 50) begin tick(); k++; end
        check("mid_burst_started", expq.size() == 2, expq.size(), 2);
        repeat (10) tick();
        @(posedge clk_in);
        #3 nrst_in = 1'b0;
        #1;
        check("arst_grant", grant_out == '0, grant_out, 0);
        check("arst_ack", ack_out == '0, ack_out, 0);
        check("arst_start", tx_start_out == 1'b0, tx_start_out, 0);
        check("arst_data", tx_data_out == '0, tx_data_out, 0);
        check("arst_err", err_timeout_out == 1'b0, err_timeout_out, 0);
        for (int i = 0; i < N; i++) begin rq[i].delete(); mq[i].delete(); end
        expq.delete();
        mptr = N - 1;
        tick(); tick();
        nrst_in = 1'b1;
        len_fix = 12;
        push_byte(3, 8'h93, 1'b1); push_byte(0, 8'h90, 1'b1);
        tick(); plan(-1);
        wait_drain("post_reset_drain", 500);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, OVERSAMPLING ticks per bit, same clock domain as uart_rx) among NUM_REQ byte-stream requesters.
- Grants are round-robin.
- A granted requester keeps the transmitter for a burst of bytes until it marks the last byte.
- The block sequences the transmitter's start/busy handshake and reports a stall if the transmitter never responds.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_BITS, 8, byte width, matches uart_rx/uart_tx
- START_TIMEOUT, 16, max clk_in cycles from tx_start_out to tx_busy_in rising

Ports:
- clk_in  input  1  system clock
- nrst_in  input  1  asynchronous active-low reset
- req_in  input  NUM_REQ  per-requester byte valid
- data_in  input  NUM_REQ*DATA_BITS  per-requester byte; requester i at [i*DATA_BITS +: DATA_BITS]
- last_in  input  NUM_REQ  byte is last of burst, qualified by req_in
- ack_out  output  NUM_REQ  one-cycle pulse: requester's byte accepted
- grant_out  output  NUM_REQ  one-hot current owner, 0 when idle
- tx_start_out  output  1  one-cycle start pulse to transmitter
- tx_data_out  output  DATA_BITS  byte to transmit, held from start until busy falls
- tx_busy_in  input  1  transmitter busy (start bit through stop bit)
- err_timeout_out  output  1  sticky: transmitter failed to assert busy

Behaviour:
- Reset: one clock, clk_in; nrst_in is asynchronous, active-low.
  - All outputs are 0; state IDLE.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-burst aborts immediately; no ack is issued.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Proceeds when (req_in != 0) and tx_busy_in == 0.
  - Selects the first set req_in bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Registers grant_out; next state START. Arbitration is exactly 1 cycle.
- START (1 cycle):
  - If req_in[owner] is still set:
    - tx_start_out = 1; tx_data_out <= data_in[owner].
    - ack_out[owner] = 1; capture last_flag <= last_in[owner].
    - Next state WAIT_BUSY.
  - If req_in[owner] has dropped: grant_out <= 0, pointer <= owner, next state IDLE, no start.
- WAIT_BUSY:
  - Counts cycles.
  - If tx_busy_in == 1: next state WAIT_DONE.
  - If count reaches START_TIMEOUT: set err_timeout_out, release grant, pointer <= owner, next state IDLE.
  - Busy already high in the cycle after start is legal (count 1).
- WAIT_DONE:
  - On tx_busy_in == 0:
    - If last_flag: grant_out <= 0, pointer <= owner, next state IDLE.
    - Else: next state START with the same owner; other requesters wait.
  - Byte-to-byte gap is 1 cycle after busy falls.
- Fairness: after a burst ends, the owner has lowest priority. Simultaneous requests are resolved purely by pointer order.
- tx_data_out holds until the next START; it is not cleared on release.
- ack_out and tx_start_out are asserted in the same cycle.
- A requester must hold data_in and last_in stable while req_in is high until ack.
- err_timeout_out clears only on reset.
- Requests arriving while busy are not lost: req_in is level-sensitive.
- Single requester with NUM_REQ=1 is out of scope (parameter check: NUM_REQ >= 2).

Decomposition:
- uart_pkg holds:
  - state encoding localparams ARB_IDLE=2'b00, ARB_START=2'b01, ARB_WAIT_BUSY=2'b10, ARB_WAIT_DONE=2'b11
  - the DATA_BITS default, shared with uart_rx/uart_tx
- One combinational sub-module, uart_rr_select: inputs are the request vector and pointer; outputs are a one-hot grant and a valid flag (double-width mask-and-priority method).
- The FSM, timeout counter and data mux stay in the top module.

Test Plan:
- Single byte: req_in=4'b0010, data 8'hA5, last=1, TX model busy 80 cycles.
  - Required: ack_out[1] and tx_start_out pulse together 2 cycles after req; tx_data_out=8'hA5.
  - Required: grant_out returns to 0 one cycle after busy falls.
- Round-robin: req_in=4'b1111 held, each byte last=1.
  - Required: grant order 0,1,2,3,0.
  - Required: exactly one ack per grant.
- Burst lock: requester 2 sends 3 bytes (11,22,33, last on 33) while requester 0 requests.
  - Required: the 3 bytes go out consecutively before requester 0 is granted.
  - Required: each inter-byte gap is 1 cycle after busy falls.
- Timeout: TX model never asserts busy.
  - Required: err_timeout_out=1 exactly START_TIMEOUT cycles after start, grant released.
  - Required: the next requester is served normally and err remains 1.
- Request withdrawn: req_in[3] drops in the START cycle.
  - Required: no tx_start_out, no ack; return to IDLE.
  - Required: requester 3 gets lowest priority afterwards.
- Async reset mid WAIT_DONE: assert nrst_in low between clock edges.
  - Required: all outputs 0 immediately without a clock edge.
  - Required: after release, requester 0 has first priority.
